// File: rtl/cpu_pkg.sv
// State codes shared by the controller and the fetch unit, plus small fetch helpers.
package cpu_pkg;

    localparam logic [7:0] ST_FETCH_PC      = 8'h01;
    localparam logic [7:0] ST_FETCH_INST    = 8'h02;
    localparam logic [7:0] ST_HALT          = 8'h03;
    localparam logic [7:0] ST_JUMP          = 8'h04;
    localparam logic [7:0] ST_RET           = 8'h0F;
    localparam logic [7:0] ST_LDI_FETCH_IMM = 8'h15;

    // Loaded into the target register when a read times out.
    localparam logic [7:0] NOP_INSTR = 8'h00;

    function automatic logic [7:0] pc_inc(input logic [7:0] p);
        return p + 8'd1;
    endfunction

endpackage

// File: rtl/cpu_fetch_wdog.sv
// Read-timeout counter for cpu_fetch; exists only when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module cpu_fetch_wdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic busy,
    input  logic ack,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (busy && !ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive cycle without an acknowledge.
    assign timeout = busy && !ack && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule
`endif

// File: rtl/cpu_fetch.sv
// Instruction/immediate fetch unit driven by controller state codes.
// Optional read timeout enabled with FETCH_TIMEOUT_EN.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         TIMEOUT_CYC = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] state,
    input  logic [7:0] bus_in,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    output logic [7:0] instruction,
    output logic [7:0] imm,
    output logic [7:0] pc,
    output logic       stall,
    output logic       halted,
    output logic       fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        RD_INST,
        RD_IMM,
        HALTED
    } fetch_state_t;

    fetch_state_t fsm;
    logic [7:0]   mar;
    logic         busy;
    logic         read_start;
    logic         timeout;

    assign busy       = (fsm == RD_INST) || (fsm == RD_IMM);
    assign read_start = (fsm == IDLE) &&
                        ((state == ST_FETCH_INST) || (state == ST_LDI_FETCH_IMM));
    assign stall      = busy;
    assign mem_addr   = mar;

`ifdef FETCH_TIMEOUT_EN
    logic err_q;

    cpu_fetch_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .start   (read_start),
        .busy    (busy),
        .ack     (mem_ack),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm         <= IDLE;
            pc          <= RESET_PC;
            mar         <= 8'h00;
            instruction <= 8'h00;
            imm         <= 8'h00;
            mem_req     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    case (state)
                        ST_FETCH_PC: mar <= pc;
                        ST_FETCH_INST: begin
                            fsm     <= RD_INST;
                            mem_req <= 1'b1;
                        end
                        ST_LDI_FETCH_IMM: begin
                            mar     <= pc;
                            fsm     <= RD_IMM;
                            mem_req <= 1'b1;
                        end
                        ST_JUMP, ST_RET: pc <= bus_in;
                        ST_HALT: begin
                            fsm    <= HALTED;
                            halted <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                RD_INST: begin
                    if (mem_ack) begin
                        instruction <= mem_rdata;
                        pc          <= pc_inc(pc);
                        fsm         <= IDLE;
                        mem_req     <= 1'b0;
                    end else if (timeout) begin
                        instruction <= NOP_INSTR;
                        fsm         <= IDLE;
                        mem_req     <= 1'b0;
                    end
                end
                RD_IMM: begin
                    if (mem_ack) begin
                        imm     <= mem_rdata;
                        pc      <= pc_inc(pc);
                        fsm     <= IDLE;
                        mem_req <= 1'b0;
                    end else if (timeout) begin
                        imm     <= NOP_INSTR;
                        fsm     <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                // Frozen until reset.
                HALTED: ;
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYC, default 15, cycles waited for mem_ack before a timeout (used only when FETCH_TIMEOUT_EN is defined).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port state, input, 8 bits: controller state code, per cpu_pkg encodings.
REQ-006 Port bus_in, input, 8 bits: jump or return target from the data bus.
REQ-007 Port mem_rdata, input, 8 bits: program memory read data.
REQ-008 Port mem_ack, input, 1 bit: mem_rdata valid this cycle.
REQ-009 Port mem_req, output, 1 bit: read request.
REQ-010 Port mem_addr, output, 8 bits: read address (MAR).
REQ-011 Port instruction, output, 8 bits: instruction register, feeds the controller.
REQ-012 Port imm, output, 8 bits: immediate operand register.
REQ-013 Port pc, output, 8 bits: program counter.
REQ-014 Port stall, output, 1 bit: controller must hold its cycle count.
REQ-015 Port halted, output, 1 bit: sticky halt flag.
REQ-016 Port fetch_err, output, 1 bit: timeout flag (FETCH_TIMEOUT_EN only).

Function
REQ-017 The internal FSM SHALL have the states IDLE, RD_INST, RD_IMM and HALTED.
REQ-018 In IDLE with state==FETCH_PC (8'h01), MAR SHALL load pc.
REQ-019 In IDLE with state==FETCH_INST (8'h02), the FSM SHALL go to RD_INST.
REQ-020 In IDLE with state==LDI_FETCH_IMM (8'h15), MAR SHALL load pc and the FSM SHALL go to RD_IMM.
REQ-021 mem_req SHALL be high exactly while the FSM is in RD_INST or RD_IMM, and mem_addr SHALL equal MAR throughout.
REQ-022 In RD_INST with mem_ack=1, instruction SHALL load mem_rdata, pc SHALL increment, and the FSM SHALL return to IDLE on the same edge.
REQ-023 In RD_IMM with mem_ack=1, imm SHALL load mem_rdata, pc SHALL increment, and the FSM SHALL return to IDLE.
REQ-024 Minimum latency from a fetch state to the captured data SHALL be 2 edges (mem_ack high in the first request cycle).
REQ-025 stall SHALL be combinationally high while in RD_INST or RD_IMM.
REQ-026 While the FSM is busy (RD_INST or RD_IMM), all state codes SHALL be ignored, including HALT.
REQ-027 In IDLE with state==JUMP (8'h04) or RET (8'h0F), pc SHALL load bus_in.
REQ-028 In IDLE with state==HALT (8'h03), the FSM SHALL enter HALTED.
REQ-029 In HALTED, halted=1, mem_req=0, stall=0, and pc, instruction and imm SHALL be frozen until reset.
REQ-030 PC increment SHALL be modulo 256 (8'hFF wraps to 8'h00).
REQ-031 mem_ack received in IDLE or HALTED SHALL be ignored.
REQ-032 All other state codes SHALL cause no action.

Reset
REQ-033 Reset SHALL dominate every other input on any edge, including mid-read.
REQ-034 Reset values: pc=RESET_PC, MAR=8'h00, instruction=8'h00, imm=8'h00, FSM=IDLE, mem_req=0, stall=0, halted=0, fetch_err=0.
REQ-035 A read in flight at reset SHALL be abandoned, and a late mem_ack SHALL be ignored.

Configuration
REQ-036 With FETCH_TIMEOUT_EN defined, a wait counter SHALL clear when a read starts and count each cycle without mem_ack.
REQ-037 When the counter reaches TIMEOUT_CYC, the target register SHALL load 8'h00 (NOP), pc SHALL NOT increment, fetch_err SHALL set (sticky until reset), and the FSM SHALL return to IDLE.
REQ-038 Without FETCH_TIMEOUT_EN, reads SHALL wait indefinitely, fetch_err SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-039 The state code constants SHALL live in package cpu_pkg and be shared with the controller.
REQ-040 The fetch FSM state enum SHALL be local to cpu_fetch.
REQ-041 One sub-module is natural: cpu_fetch_wdog (the timeout counter), instantiated only under FETCH_TIMEOUT_EN; no other sub-modules.

Verification
REQ-042 Reset, then FETCH_PC followed by FETCH_INST, with mem_ack=1 in the first request cycle and mem_rdata=8'h10 -> mem_addr=8'h00, instruction=8'h10, pc=8'h01, stall high for 1 cycle.
REQ-043 FETCH_INST with mem_ack held low for 3 cycles, then rdata=8'h45 -> stall high for 4 cycles, instruction=8'h45, JUMP presented during the stall is ignored.
REQ-044 JUMP with bus_in=8'hFF, then FETCH_PC and FETCH_INST -> mem_addr=8'hFF and pc wraps to 8'h00; then LDI_FETCH_IMM with rdata=8'h2A -> imm=8'h2A, pc=8'h01.
REQ-045 HALT, then FETCH_INST with mem_ack pulses -> halted=1, mem_req=0, pc unchanged; reset clears halted.
REQ-046 Reset asserted during RD_INST, with a late mem_ack and rdata=8'h99 -> instruction=8'h00, pc=RESET_PC.
REQ-047 With FETCH_TIMEOUT_EN defined and mem_ack never asserted -> after 15 cycles instruction=8'h00, fetch_err=1, pc not incremented.
